// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command decoder: command opcodes, response
// status codes, the decoder state enum and a small opcode helper.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;

   localparam logic [7:0] STAT_ACK  = 8'h06;
   localparam logic [7:0] STAT_NAK  = 8'h15;

   // Write payload and read response are always one 32-bit word.
   localparam int DATA_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP_STAT,
      ST_RESP_DATA
   } state_t;

   // True for the two opcodes that start a frame.
   function automatic logic isCommand(input logic [7:0] b);
      return (b == CMD_WRITE) || (b == CMD_READ);
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// ---------------------------------------------------------------------------
// uart_cmd_timeout
// Saturating cycle counter used as a watchdog. Counts while enabled, holds at
// LIMIT, and flags expiry once LIMIT has been reached.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   i_clear    in   synchronous clear (takes priority over enable)
//   i_enable   in   count one cycle
//   o_expired  out  counter has reached LIMIT
// ---------------------------------------------------------------------------
module uart_cmd_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_count;

   // The count stops at LIMIT instead of wrapping so a long stall can never
   // alias back into a "fresh" count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != W'(LIMIT))) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == W'(LIMIT));

endmodule

// File: rtl/uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// uart_cmd_decoder
// Parses binary command frames arriving from the UART receiver, runs one
// register-bus transaction per frame and returns a status byte (plus four
// data bytes for a successful read) to the UART transmitter.
// Frame: CMD (0x57 write / 0x52 read), ADDR big-endian, DATA (writes only,
// 4 bytes big-endian). Response: 0x06 ACK or 0x15 NAK, read ACK adds data.
// Ports:
//   aclk, aresetn               clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready  received byte stream (target)
//   m_axis_tdata/tvalid/tready  response byte stream (host)
//   en_o, wr_o, addr_o, dat_o   register-bus request
//   dat_i, ack_i                register-bus read data and completion
// ---------------------------------------------------------------------------
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter  int ADDR_BYTES   = 2,
   parameter  int BYTE_TIMEOUT = 50000,
   parameter  int BUS_TIMEOUT  = 255,
   localparam int ADDR_BITS    = 8 * ADDR_BYTES
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic [7:0]           s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 en_o,
   output logic                 wr_o,
   output logic [ADDR_BITS-1:0] addr_o,
   output logic [31:0]          dat_o,
   input  logic [31:0]          dat_i,
   input  logic                 ack_i
);

   localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
   localparam int CNT_W     = $clog2(MAX_BYTES) + 1;

   state_t               r_state;
   state_t               w_stateNext;
   logic                 r_wr;
   logic [ADDR_BITS-1:0] r_addr;
   logic [31:0]          r_dat;
   logic [31:0]          r_rdata;
   logic [7:0]           r_stat;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_tvalid;
   logic [7:0]           r_tdata;

   logic w_inFrame;
   logic w_accept;
   logic w_txHs;
   logic w_ack;
   logic w_lastAddr;
   logic w_lastData;
   logic w_lastResp;
   logic w_byteExpired;
   logic w_busExpired;
   logic w_busRun;

   // Input is only taken while collecting a frame and nothing is waiting to
   // be sent; reset forces it low so nothing is accepted while held in reset.
   assign w_inFrame     = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_DATA);
   assign s_axis_tready = aresetn && w_inFrame && !r_tvalid;
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_txHs        = r_tvalid && m_axis_tready;
   assign w_ack         = en_o && ack_i;
   assign w_lastAddr    = (r_cnt == CNT_W'(ADDR_BYTES - 1));
   assign w_lastData    = (r_cnt == CNT_W'(DATA_BYTES - 1));
   assign w_lastResp    = (r_cnt == CNT_W'(DATA_BYTES - 1));

   assign en_o          = (r_state == ST_BUS);
   assign wr_o          = r_wr;
   assign addr_o        = r_addr;
   assign dat_o         = r_dat;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_tdata;

   // Inter-byte watchdog: restarts on every accepted byte, only runs while a
   // frame is partially received.
   uart_cmd_timeout #(
      .LIMIT     (BYTE_TIMEOUT)
   ) u_byteTimeout (
      .clk       (aclk),
      .rst_n     (aresetn),
      .i_clear   (w_accept || !((r_state == ST_ADDR) || (r_state == ST_DATA))),
      .i_enable  (1'b1),
      .o_expired (w_byteExpired)
   );

   // Bus watchdog starts counting on the edge that enters BUS, so the count
   // equals the number of cycles en_o has been high.
   assign w_busRun = (r_state == ST_BUS) || (w_stateNext == ST_BUS);

   uart_cmd_timeout #(
      .LIMIT     (BUS_TIMEOUT)
   ) u_busTimeout (
      .clk       (aclk),
      .rst_n     (aresetn),
      .i_clear   (!w_busRun),
      .i_enable  (w_busRun),
      .o_expired (w_busExpired)
   );

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic. An accepted byte always beats a byte timeout on the
   // same cycle, and an ack always beats a bus timeout on the same cycle.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_stateNext = isCommand(s_axis_tdata) ? ST_ADDR : ST_RESP_STAT;
            end
         end
         ST_ADDR: begin
            if (w_accept) begin
               if (w_lastAddr) begin
                  w_stateNext = r_wr ? ST_DATA : ST_BUS;
               end
            end else if (w_byteExpired) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (w_accept) begin
               if (w_lastData) begin
                  w_stateNext = ST_BUS;
               end
            end else if (w_byteExpired) begin
               w_stateNext = ST_IDLE;
            end
         end
         ST_BUS: begin
            if (w_ack || w_busExpired) begin
               w_stateNext = ST_RESP_STAT;
            end
         end
         ST_RESP_STAT: begin
            if (w_txHs) begin
               w_stateNext = ((r_stat == STAT_ACK) && !r_wr) ? ST_RESP_DATA : ST_IDLE;
            end
         end
         ST_RESP_DATA: begin
            if (w_txHs && w_lastResp) begin
               w_stateNext = ST_IDLE;
            end
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Datapath: frame capture, bus result capture and response streaming.
   // The status byte is loaded one cycle after entering RESP_STAT; each data
   // byte is loaded on the handshake of the byte before it, so tvalid can
   // stay high across the data bytes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_dat    <= '0;
         r_rdata  <= '0;
         r_stat   <= STAT_NAK;
         r_cnt    <= '0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  if (isCommand(s_axis_tdata)) begin
                     r_wr <= (s_axis_tdata == CMD_WRITE);
                  end else begin
                     r_stat <= STAT_NAK;
                  end
               end
            end
            ST_ADDR: begin
               if (w_accept) begin
                  r_addr <= (r_addr << 8) | ADDR_BITS'(s_axis_tdata);
                  r_cnt  <= w_lastAddr ? '0 : r_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (w_accept) begin
                  r_dat <= {r_dat[23:0], s_axis_tdata};
                  r_cnt <= w_lastData ? '0 : r_cnt + 1'b1;
               end
            end
            ST_BUS: begin
               if (w_ack) begin
                  r_stat <= STAT_ACK;
                  if (!r_wr) begin
                     r_rdata <= dat_i;
                  end
               end else if (w_busExpired) begin
                  r_stat <= STAT_NAK;
               end
            end
            ST_RESP_STAT: begin
               if (!r_tvalid) begin
                  r_tvalid <= 1'b1;
                  r_tdata  <= r_stat;
               end else if (m_axis_tready) begin
                  if ((r_stat == STAT_ACK) && !r_wr) begin
                     r_tdata <= r_rdata[31:24];
                     r_rdata <= r_rdata << 8;
                     r_cnt   <= '0;
                  end else begin
                     r_tvalid <= 1'b0;
                  end
               end
            end
            ST_RESP_DATA: begin
               if (w_txHs) begin
                  if (w_lastResp) begin
                     r_tvalid <= 1'b0;
                     r_cnt    <= '0;
                  end else begin
                     r_tdata <= r_rdata[31:24];
                     r_rdata <= r_rdata << 8;
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_decoder
// Directed self-checking bench for uart_cmd_decoder. Inputs change and
// outputs are sampled on the falling edge of aclk.
// ---------------------------------------------------------------------------
module tb_uart_cmd_decoder;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        en_o;
   logic        wr_o;
   logic [15:0] addr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i = '0;
   logic        ack_i = 1'b0;

   int errors = 0;
   int checks = 0;

   uart_cmd_decoder #(
      .ADDR_BYTES    (2),
      .BYTE_TIMEOUT  (50000),
      .BUS_TIMEOUT   (255)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .en_o          (en_o),
      .wr_o          (wr_o),
      .addr_o        (addr_o),
      .dat_o         (dat_o),
      .dat_i         (dat_i),
      .ack_i         (ack_i)
   );

   // 100 MHz bench clock.
   always #5 aclk = ~aclk;

   // Offer one byte (called on a falling edge); returns on the falling edge
   // after the handshake edge. A stuck tready is reported and abandoned.
   task automatic applyStimulus(input logic [7:0] b);
      bit done = 1'b0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (s_axis_tready) begin
            @(posedge aclk);
            done = 1'b1;
         end
         @(negedge aclk);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL send_%h: s_axis_tready=0 for 200 cycles, required 1", b);
      end
   endtask

   // Accept one response byte; returns X if none arrives within the bound.
   task automatic recvByte(output logic [7:0] b);
      bit done = 1'b0;
      b = 8'hxx;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 400 && !done; i++) begin
         if (m_axis_tvalid) begin
            b = m_axis_tdata;
            @(posedge aclk);
            done = 1'b1;
         end
         @(negedge aclk);
      end
      m_axis_tready = 1'b0;
   endtask

   // One-cycle ack with read data, driven on the current falling edge.
   task automatic pulseAck(input logic [31:0] d);
      ack_i = 1'b1;
      dat_i = d;
      @(negedge aclk);
      ack_i = 1'b0;
      dat_i = '0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, en_o, wr_o, addr_o, dat_o} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: tready=%b tvalid=%b tdata=%h en=%b wr=%b addr=%h dat=%h, required all 0",
                  s_axis_tready, m_axis_tvalid, m_axis_tdata, en_o, wr_o, addr_o, dat_o);
      end
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_release_tready: got %b, required 1", s_axis_tready);
      end
   endtask

   task automatic test_write();
      logic [7:0] frame [7] = '{8'h57, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      logic [7:0] b;
      bit         enDrop = 1'b0;
      foreach (frame[i]) applyStimulus(frame[i]);
      checks++;
      if ({en_o, wr_o, addr_o, dat_o} !== {1'b1, 1'b1, 16'h1234, 32'hDEADBEEF}) begin
         errors++;
         $display("[TB] FAIL write_request: en=%b wr=%b addr=%h dat=%h, required 1 1 1234 deadbeef",
                  en_o, wr_o, addr_o, dat_o);
      end
      repeat (3) begin
         @(negedge aclk);
         if (en_o !== 1'b1 || addr_o !== 16'h1234 || dat_o !== 32'hDEADBEEF) enDrop = 1'b1;
      end
      checks++;
      if (enDrop) begin
         errors++;
         $display("[TB] FAIL write_hold: en/addr/dat changed before ack, required stable");
      end
      pulseAck(32'h0);
      checks++;
      if ({en_o, m_axis_tvalid} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL write_ack_plus1: en=%b tvalid=%b, required 0 0", en_o, m_axis_tvalid);
      end
      @(negedge aclk);
      checks++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h06}) begin
         errors++;
         $display("[TB] FAIL write_ack_plus2: tvalid=%b tdata=%h, required 1 06", m_axis_tvalid, m_axis_tdata);
      end
      recvByte(b);
      checks++;
      if (b !== 8'h06) begin
         errors++;
         $display("[TB] FAIL write_status: got %h, required 06", b);
      end
      checks++;
      if ({s_axis_tready, m_axis_tvalid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL write_after_resp: tready=%b tvalid=%b, required 1 0", s_axis_tready, m_axis_tvalid);
      end
      enDrop = 1'b0;
      repeat (5) begin
         @(negedge aclk);
         if (m_axis_tvalid !== 1'b0) enDrop = 1'b1;
      end
      checks++;
      if (enDrop) begin
         errors++;
         $display("[TB] FAIL write_no_extra: tvalid=1 after status, required 0");
      end
   endtask

   task automatic test_read();
      logic [7:0] exp [5] = '{8'h06, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      logic [7:0] b;
      bit         moved = 1'b0;
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h10);
      checks++;
      if ({en_o, wr_o, addr_o} !== {1'b1, 1'b0, 16'h0010}) begin
         errors++;
         $display("[TB] FAIL read_request: en=%b wr=%b addr=%h, required 1 0 0010", en_o, wr_o, addr_o);
      end
      pulseAck(32'hCAFEF00D);
      for (int i = 0; i < 2; i++) begin
         recvByte(b);
         checks++;
         if (b !== exp[i]) begin
            errors++;
            $display("[TB] FAIL read_byte%0d: got %h, required %h", i, b, exp[i]);
         end
      end
      repeat (5) begin
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hFE) moved = 1'b1;
         @(negedge aclk);
      end
      checks++;
      if (moved) begin
         errors++;
         $display("[TB] FAIL read_stall: tvalid/tdata changed while tready low, required 1/fe");
      end
      for (int i = 2; i < 5; i++) begin
         recvByte(b);
         checks++;
         if (b !== exp[i]) begin
            errors++;
            $display("[TB] FAIL read_byte%0d: got %h, required %h", i, b, exp[i]);
         end
      end
      checks++;
      if ({s_axis_tready, m_axis_tvalid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL read_done: tready=%b tvalid=%b, required 1 0", s_axis_tready, m_axis_tvalid);
      end
   endtask

   task automatic test_bad_opcode();
      logic [7:0] exp [5] = '{8'h06, 8'h12, 8'h34, 8'h56, 8'h78};
      logic [7:0] b;
      bit         sawEn = 1'b0;
      applyStimulus(8'h41);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 5 && b !== 8'h15; i++) begin
         if (en_o) sawEn = 1'b1;
         if (m_axis_tvalid) b = m_axis_tdata;
         @(negedge aclk);
      end
      m_axis_tready = 1'b0;
      checks++;
      if (b !== 8'h15 || sawEn) begin
         errors++;
         $display("[TB] FAIL bad_opcode: status=%h en_seen=%b, required 15 0", b, sawEn);
      end
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h20);
      checks++;
      if ({en_o, addr_o} !== {1'b1, 16'h0020}) begin
         errors++;
         $display("[TB] FAIL bad_then_read_req: en=%b addr=%h, required 1 0020", en_o, addr_o);
      end
      pulseAck(32'h12345678);
      for (int i = 0; i < 5; i++) begin
         recvByte(b);
         checks++;
         if (b !== exp[i]) begin
            errors++;
            $display("[TB] FAIL bad_then_read_byte%0d: got %h, required %h", i, b, exp[i]);
         end
      end
   endtask

   task automatic test_bus_timeout();
      logic [7:0] b;
      int         n = 0;
      bit         extra = 1'b0;
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h30);
      while (en_o && n < 1000) begin
         n++;
         @(negedge aclk);
      end
      checks++;
      if (n != 255) begin
         errors++;
         $display("[TB] FAIL bus_timeout_len: en_o high %0d cycles, required 255", n);
      end
      pulseAck(32'hFFFF_FFFF);
      recvByte(b);
      checks++;
      if (b !== 8'h15) begin
         errors++;
         $display("[TB] FAIL bus_timeout_status: got %h, required 15", b);
      end
      repeat (8) begin
         if (m_axis_tvalid !== 1'b0 || en_o !== 1'b0) extra = 1'b1;
         @(negedge aclk);
      end
      checks++;
      if (extra) begin
         errors++;
         $display("[TB] FAIL bus_timeout_quiet: tvalid or en_o high after NAK, required 0");
      end
   endtask

   task automatic test_byte_timeout();
      logic [7:0] exp [5] = '{8'h06, 8'hA5, 8'hA5, 8'h00, 8'h01};
      logic [7:0] b;
      bit         noise = 1'b0;
      applyStimulus(8'h57);
      applyStimulus(8'h12);
      repeat (50100) begin
         if (en_o !== 1'b0 || m_axis_tvalid !== 1'b0) noise = 1'b1;
         @(negedge aclk);
      end
      checks++;
      if (noise) begin
         errors++;
         $display("[TB] FAIL byte_timeout_silent: en_o or tvalid rose, required 0");
      end
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      checks++;
      if ({en_o, wr_o, addr_o} !== {1'b1, 1'b0, 16'h0001}) begin
         errors++;
         $display("[TB] FAIL byte_timeout_next_req: en=%b wr=%b addr=%h, required 1 0 0001", en_o, wr_o, addr_o);
      end
      pulseAck(32'hA5A50001);
      for (int i = 0; i < 5; i++) begin
         recvByte(b);
         checks++;
         if (b !== exp[i]) begin
            errors++;
            $display("[TB] FAIL byte_timeout_byte%0d: got %h, required %h", i, b, exp[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] exp [5] = '{8'h06, 8'h0B, 8'hAD, 8'hC0, 8'hDE};
      logic [7:0] frame [7] = '{8'h57, 8'hAB, 8'hCD, 8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] b;
      bit         resumed = 1'b0;
      // Reset in the middle of the data bytes of a read response.
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h40);
      pulseAck(32'h99887766);
      recvByte(b);
      recvByte(b);
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if ({s_axis_tready, m_axis_tvalid, m_axis_tdata, en_o, wr_o, addr_o, dat_o} !== '0) begin
         errors++;
         $display("[TB] FAIL areset_resp: tready=%b tvalid=%b tdata=%h en=%b addr=%h, required all 0",
                  s_axis_tready, m_axis_tvalid, m_axis_tdata, en_o, addr_o);
      end
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      @(negedge aclk);
      checks++;
      if ({s_axis_tready, m_axis_tvalid} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL areset_resp_release: tready=%b tvalid=%b, required 1 0", s_axis_tready, m_axis_tvalid);
      end
      // Reset while a write transaction is on the bus.
      foreach (frame[i]) applyStimulus(frame[i]);
      #2 aresetn = 1'b0;
      #1;
      checks++;
      if ({s_axis_tready, m_axis_tvalid, en_o, wr_o, addr_o, dat_o} !== '0) begin
         errors++;
         $display("[TB] FAIL areset_bus: tready=%b en=%b wr=%b addr=%h dat=%h, required all 0",
                  s_axis_tready, en_o, wr_o, addr_o, dat_o);
      end
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      repeat (10) begin
         @(negedge aclk);
         if (en_o !== 1'b0 || m_axis_tvalid !== 1'b0) resumed = 1'b1;
      end
      checks++;
      if (resumed) begin
         errors++;
         $display("[TB] FAIL areset_no_resume: en_o or tvalid rose after reset, required 0");
      end
      applyStimulus(8'h52);
      applyStimulus(8'h00);
      applyStimulus(8'h44);
      checks++;
      if ({en_o, wr_o, addr_o} !== {1'b1, 1'b0, 16'h0044}) begin
         errors++;
         $display("[TB] FAIL areset_next_req: en=%b wr=%b addr=%h, required 1 0 0044", en_o, wr_o, addr_o);
      end
      pulseAck(32'h0BADC0DE);
      for (int i = 0; i < 5; i++) begin
         recvByte(b);
         checks++;
         if (b !== exp[i]) begin
            errors++;
            $display("[TB] FAIL areset_next_byte%0d: got %h, required %h", i, b, exp[i]);
         end
      end
   endtask

   // Scenarios run back to back; each one leaves the decoder in IDLE.
   initial begin
      @(negedge aclk);
      test_reset();
      test_write();
      test_read();
      test_bad_opcode();
      test_bus_timeout();
      test_byte_timeout();
      test_async_reset();
      repeat (2) @(negedge aclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
